// File: rtl/acds_pkg.sv
// ----------------------------------------------------------------------------
// acds_pkg
//  Shared types and constants for the ACDS precharged wired-OR lane driver.
//  Contents:
//   ACDS_LANES   default number of bus lanes (12)
//   ACDS_LANE_W  width of a lane index (4 bits, addresses up to 16 lanes)
//   lane_t       lane index type
//   drv_state_e  driver phase FSM states {IDLE, PRE, EVAL}
//   acds_word_t  default {lane, data} word for the one-byte-per-lane build
// ----------------------------------------------------------------------------
package acds_pkg;

    localparam int ACDS_LANES  = 12;
    localparam int ACDS_LANE_W = 4;

    typedef logic [ACDS_LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2
    } drv_state_e;

    typedef struct packed {
        lane_t      lane;
        logic [7:0] data;
    } acds_word_t;

endpackage

// File: rtl/acds_drv_fifo.sv
// ----------------------------------------------------------------------------
// acds_drv_fifo
//  Synchronous FIFO of {lane, data} words feeding the lane driver.
//  The stored type is a parameter so the top can widen the data field.
//  Ports:
//   clk          clock, all updates on posedge
//   rst          asynchronous active-high reset (empties the FIFO)
//   push_i       write push_word_i (ignored when full)
//   push_word_i  word to store
//   pop_i        drop the head word (ignored when empty)
//   pop_word_o   current head word (valid while !empty_o)
//   full_o       DEPTH words stored
//   empty_o      no words stored
//   count_o      number of stored words, log2(DEPTH)+1 bits
// ----------------------------------------------------------------------------
module acds_drv_fifo
    import acds_pkg::*;
#(
    parameter type word_t = acds_word_t,
    parameter int  DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  word_t                  push_word_i,
    input  logic                   pop_i,
    output word_t                  pop_word_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    word_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           push_ok;
    logic           pop_ok;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_word_o = mem[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: the storage array has no reset; the pointers and count define which
    // entries are meaningful, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_word_i;
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/acds_lane_driver.sv
// ----------------------------------------------------------------------------
// acds_lane_driver
//  Transmit end of the ACDS precharged wired-OR lane bus. Buffers {lane, data}
//  words, sequences precharge/evaluate phases and drives one word per
//  evaluate window onto its lane.
//  Ports:
//   clkPHASE    clock, all updates on posedge
//   rst         asynchronous active-high reset
//   in_valid    producer word valid
//   in_ready    FIFO not full (does not look at a same-cycle pop)
//   in_lane     target lane
//   in_data     word to drive
//   bus_pre     precharge requested (IDLE and PRE)
//   bus_eval    evaluate window
//   bus_drv_en  one-hot lane drive enable, only during EVAL
//   bus_drv_d   drive data, zero on non-enabled lanes
//   bus_rd      resolved bus value, readback only
//   err_lane    1-clk pulse after a word for a bad lane was dropped
//   contend     1-clk pulse after a readback mismatch
//  Build option:
//   ACDS_DRV_READBACK_EN  enables the readback contention check; when not
//                         defined bus_rd is ignored and contend is tied low.
// ----------------------------------------------------------------------------
module acds_lane_driver
    import acds_pkg::*;
#(
    parameter int               WIDTH      = 1,
    parameter int               LANES      = ACDS_LANES,
    parameter logic [LANES-1:0] LANE_MASK  = {LANES{1'b1}},
    parameter int               PRE_CYC    = 1,
    parameter int               EVAL_CYC   = 1,
    parameter int               FIFO_DEPTH = 4
) (
    input  logic                     clkPHASE,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ACDS_LANE_W-1:0]   in_lane,
    input  logic [WIDTH*8-1:0]       in_data,
    output logic                     bus_pre,
    output logic                     bus_eval,
    output logic [LANES-1:0]         bus_drv_en,
    output logic [LANES*WIDTH*8-1:0] bus_drv_d,
    input  logic [LANES*WIDTH*8-1:0] bus_rd,
    output logic                     err_lane,
    output logic                     contend
);

    localparam int DW         = WIDTH * 8;
    localparam int BUS_W      = LANES * DW;
    localparam int LANE_SPACE = 1 << ACDS_LANE_W;
    localparam int CYC_MAX    = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
    localparam int CNT_W      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

    // Lane-valid map over the whole index space: entries at or above LANES
    // are zero, so one lookup covers both the range and the mask test.
    localparam logic [LANE_SPACE-1:0] LANE_OK_MAP = LANE_SPACE'(LANE_MASK);

    // The phase counter holds the clocks remaining after the current one.
    localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYC - 1);

    typedef struct packed {
        lane_t         lane;
        logic [DW-1:0] data;
    } word_t;

    drv_state_e                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [LANES-1:0]            drv_en_q, drv_en_d;
    logic [BUS_W-1:0]            drv_d_q, drv_d_d;
    logic                        err_lane_q;

    word_t                       push_word;
    word_t                       head_word;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
    logic                        accept;
    logic                        lane_ok;
    logic                        push_en;
    logic                        pop_en;
    logic                        eval_last;

    // ------------------------------------------------------------------
    // Input port and bad-lane filter
    // ------------------------------------------------------------------
    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign lane_ok   = LANE_OK_MAP[in_lane];
    // Bad-lane words are still accepted (handshake completes) but not stored.
    assign push_en   = accept && lane_ok;
    assign push_word = {in_lane, in_data};

    acds_drv_fifo #(
        .word_t (word_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clkPHASE),
        .rst         (rst),
        .push_i      (push_en),
        .push_word_i (push_word),
        .pop_i       (pop_en),
        .pop_word_o  (head_word),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (unused_fifo_count)
    );

    // ------------------------------------------------------------------
    // Phase FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clkPHASE or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Phase FSM: next state
    // ------------------------------------------------------------------
    always_comb begin : fsm_next
        // NOTE: every output of a combinational block gets a default before any
        // branch, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        pop_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = PRE;
                    cnt_d   = PRE_LOAD;
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    // The head word moves into the drive registers on this edge.
                    state_d = EVAL;
                    cnt_d   = EVAL_LOAD;
                    pop_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            EVAL: begin
                if (cnt_q == '0) begin
                    state_d = fifo_empty ? IDLE : PRE;
                    cnt_d   = PRE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin : fsm_out
        bus_pre   = 1'b1;
        bus_eval  = 1'b0;
        eval_last = 1'b0;
        if (state_q == EVAL) begin
            bus_pre   = 1'b0;
            bus_eval  = 1'b1;
            eval_last = (cnt_q == '0);
        end
    end

    // ------------------------------------------------------------------
    // Drive registers: loaded one-hot on the PRE->EVAL edge, cleared on
    // the EVAL exit edge, so drive is never visible outside EVAL.
    // ------------------------------------------------------------------
    always_comb begin : drive_next
        drv_en_d = drv_en_q;
        drv_d_d  = drv_d_q;
        if (pop_en) begin
            drv_en_d = '0;
            drv_d_d  = '0;
            for (int l = 0; l < LANES; l++) begin
                if (head_word.lane == ACDS_LANE_W'(l)) begin
                    drv_en_d[l]         = 1'b1;
                    drv_d_d[l*DW +: DW] = head_word.data;
                end
            end
        end else if (eval_last) begin
            drv_en_d = '0;
            drv_d_d  = '0;
        end
    end

    always_ff @(posedge clkPHASE or posedge rst) begin
        if (rst) begin
            drv_en_q   <= '0;
            drv_d_q    <= '0;
            err_lane_q <= 1'b0;
        end else begin
            drv_en_q   <= drv_en_d;
            drv_d_q    <= drv_d_d;
            err_lane_q <= accept && !lane_ok;
        end
    end

    assign bus_drv_en = drv_en_q;
    assign bus_drv_d  = drv_d_q;
    assign err_lane   = err_lane_q;

    // ------------------------------------------------------------------
    // Readback contention check
    // ------------------------------------------------------------------
`ifdef ACDS_DRV_READBACK_EN
    logic [BUS_W-1:0] lane_bits;
    logic             contend_d;
    logic             contend_q;

    // Restrict the compare to the bits of the lane currently driven.
    always_comb begin : readback_mask
        lane_bits = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_bits[l*DW +: DW] = {DW{drv_en_q[l]}};
        end
    end

    // A wired-OR bus can only add ones: any bit read high that this driver
    // did not drive means another driver is active on the lane.
    assign contend_d = eval_last && (|(bus_rd & lane_bits & ~drv_d_q));

    always_ff @(posedge clkPHASE or posedge rst) begin
        if (rst) begin
            contend_q <= 1'b0;
        end else begin
            contend_q <= contend_d;
        end
    end

    assign contend = contend_q;
`else
    logic unused_bus_rd;

    assign unused_bus_rd = ^bus_rd;
    assign contend       = 1'b0;
`endif

endmodule
